// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch path (i_*) and the load/store path (d_*).
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   i_req/i_addr        fetch request (held until i_ack)
//   i_ack/i_rdata/i_err one-cycle fetch completion with data / error
//   d_req/d_we/d_addr/d_wdata/d_be  data request (held until d_ack)
//   d_ack/d_rdata/d_err one-cycle data completion with data / error
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered memory port
//   mem_rdata/mem_ready memory read data and single-cycle completion
//   busy                state != IDLE
//   grant_d             1 = current or last grant went to the data port
//
// State table:
//   IDLE | arbitrate between i_req and d_req on the clock edge
//   BUSY | memory access in flight, waiting for mem_ready or timeout
//   DONE | one-cycle ack to the granted requester

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        grant_d
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          i_ack_q, i_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic          i_err_q, i_err_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          d_err_q, d_err_d;
  logic          busy_q, busy_d;
  logic          grant_d_q, grant_d_d;

  // Completion of the current access, steered to one requester below.
  logic          fin;
  logic          fin_err;
  logic [31:0]   fin_rdata;
  logic          fin_data;

  logic          d_win;
  logic          i_win;

  always_comb begin
    // Data wins unless fetch has waited through STARVE_LIMIT data grants.
    d_win = d_req && !(i_req && (streak_q == SLIM));
    i_win = !d_win && i_req;

    state_d     = state_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    grant_d_d   = grant_d_q;
    // Ack, rdata and err are only ever valid for the single DONE cycle.
    i_ack_d     = 1'b0;
    i_rdata_d   = 32'h0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_rdata_d   = 32'h0;
    d_err_d     = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_rdata   = 32'h0;
    fin_data    = grant_d_q;

    case (state_q)
      IDLE: begin
        if (d_win || i_win) begin
          if (d_win) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
            grant_d_d   = 1'b1;
            if (i_req) begin
              if (streak_q != SLIM) begin
                streak_d = streak_q + SW'(1);
              end
            end else begin
              streak_d = '0;
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = 32'h0;
            mem_be_d    = 4'hF;
            grant_d_d   = 1'b0;
            streak_d    = '0;
          end

          if (mem_addr_d[1:0] != 2'b00) begin
            // Misaligned: report the error without touching memory.
            state_d   = DONE;
            mem_req_d = 1'b0;
            fin       = 1'b1;
            fin_err   = 1'b1;
            fin_data  = grant_d_d;
          end else begin
            state_d   = BUSY;
            mem_req_d = 1'b1;
            timer_d   = '0;
          end
        end
      end

      BUSY: begin
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          fin       = 1'b1;
          fin_rdata = mem_we_q ? 32'h0 : mem_rdata;
        end else if ((TIMEOUT != 0) && (timer_q == TMAX)) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          fin       = 1'b1;
          fin_err   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DONE: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (fin) begin
      if (fin_data) begin
        d_ack_d   = 1'b1;
        d_rdata_d = fin_rdata;
        d_err_d   = fin_err;
      end else begin
        i_ack_d   = 1'b1;
        i_rdata_d = fin_rdata;
        i_err_d   = fin_err;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= 32'h0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
      grant_d_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      busy_q      <= busy_d;
      grant_d_q   <= grant_d_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign busy      = busy_q;
  assign grant_d   = grant_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural memory with programmable latency,
// scoreboard of expected acks filled when each request is issued.

module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready_m;
  logic        force_ready;
  logic        mem_ready;
  logic        busy;
  logic        grant_d;

  assign mem_ready = mem_ready_m | force_ready;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .grant_d   (grant_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int ack_cnt = 0;

  // memory model controls
  int          mem_lat  = 1;   // ready in this cycle of mem_req (0 = never)
  int          busy_cnt = 0;
  int          mreq_cnt = 0;
  logic [31:0] mem_data = 32'h0;
  logic        chk_mem  = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] rd, input logic err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rd;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Memory: mem_ready pulses during the mem_lat-th cycle of mem_req.
  always @(negedge clock) begin
    if (mem_req) begin
      busy_cnt++;
      mreq_cnt++;
      mem_ready_m = (mem_lat != 0) && (busy_cnt == mem_lat);
      mem_rdata   = mem_data;
      if (chk_mem) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
      end
    end else begin
      busy_cnt    = 0;
      mem_ready_m = 1'b0;
      mem_rdata   = 32'h0;
    end
  end

  // Ack monitor: every ack is popped against the scoreboard.
  always @(negedge clock) begin
    if (i_ack || d_ack) begin
      ack_cnt++;
      chk("both_ack", {31'h0, i_ack & d_ack}, 32'h0);
      if (sb.size() == 0) begin
        chk("unexp_ack", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_is_d", {31'h0, d_ack}, {31'h0, e.is_d});
        chk("grant_d", {31'h0, grant_d}, {31'h0, e.is_d});
        chk("rdata", d_ack ? d_rdata : i_rdata, e.rdata);
        chk("err", {31'h0, d_ack ? d_err : i_err}, {31'h0, e.err});
      end
    end
  end

  task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    push_exp(is_d, exp_rd, exp_err);
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clock);
      #1;
      if (is_d ? d_ack : i_ack) begin
        seen = 1;
        lat  = c;
      end
    end
    if (!seen) chk("ack_wait", 32'h0, 32'h1);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic run_both(input int n);
    int target;
    bit reached;
    target  = ack_cnt + n;
    reached = 0;
    d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF; d_wdata = 32'h0;
    i_addr = 32'h500;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < n * 10 + 20 && !reached; c++) begin
      @(negedge clock);
      #1;
      if (ack_cnt >= target) reached = 1;
    end
    if (!reached) chk("both_wait", 32'h0, 32'h1);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    int lat;
    bit hit;
    reset = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    force_ready = 1'b0;
    mem_rdata = 32'h0;
    mem_ready_m = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_grant_d", {31'h0, grant_d}, 32'h0);
    chk("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single fetch, zero-wait memory
    mem_lat = 1; mem_data = 32'hDEADBEEF;
    exp_we = 1'b0; exp_addr = 32'h100; exp_wdata = 32'h0; exp_be = 4'hF;
    chk_mem = 1'b1; mreq_cnt = 0;
    access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, lat);
    chk("fetch_lat", lat, 2);
    chk("fetch_mreq_cycles", mreq_cnt, 1);
    chk_mem = 1'b0;
    repeat (2) @(negedge clock);

    // store, 3-cycle memory
    mem_lat = 3; mem_data = 32'hFFFF_FFFF;
    exp_we = 1'b1; exp_addr = 32'h200; exp_wdata = 32'h12345678; exp_be = 4'b0011;
    chk_mem = 1'b1; mreq_cnt = 0;
    access(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 32'h0, 1'b0, lat);
    chk("store_lat", lat, 4);
    chk("store_mreq_cycles", mreq_cnt, 3);
    chk_mem = 1'b0;
    repeat (2) @(negedge clock);

    // load with data returned
    mem_lat = 2; mem_data = 32'hCAFE0123;
    access(1'b1, 1'b0, 32'h204, 32'h0, 4'hF, 32'hCAFE0123, 1'b0, lat);
    repeat (2) @(negedge clock);

    // timeout: memory never answers
    mem_lat = 0; mreq_cnt = 0; mem_data = 32'h5555AAAA;
    access(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 32'h0, 1'b1, lat);
    chk("tmo_mreq_cycles", mreq_cnt, 16);
    @(negedge clock);
    #1;
    force_ready = 1'b1;   // stray pulse while IDLE
    @(negedge clock);
    #1;
    force_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("stray_busy", {31'h0, busy}, 32'h0);
    chk("stray_mem_req", {31'h0, mem_req}, 32'h0);

    // ready on the last allowed cycle beats the timeout
    mem_lat = 16; mreq_cnt = 0; mem_data = 32'h0BADF00D;
    access(1'b0, 1'b0, 32'h304, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, lat);
    chk("edge_mreq_cycles", mreq_cnt, 16);
    repeat (2) @(negedge clock);

    // misaligned fetch and data: no memory access
    mem_lat = 1; mreq_cnt = 0;
    access(1'b0, 1'b0, 32'h102, 32'h0, 4'h0, 32'h0, 1'b1, lat);
    repeat (2) @(negedge clock);
    access(1'b1, 1'b0, 32'h201, 32'h0, 4'hF, 32'h0, 1'b1, lat);
    chk("misal_mreq_cycles", mreq_cnt, 0);
    repeat (2) @(negedge clock);

    // anti-starvation: D,D,D,D,I,D,D,D,D,I
    mem_lat = 1; mem_data = 32'h13572468;
    for (int k = 0; k < 10; k++) push_exp((k % 5) != 4, 32'h13572468, 1'b0);
    run_both(10);
    repeat (2) @(negedge clock);

    // build streak to 3, then abort a 4th data grant with reset
    for (int k = 0; k < 3; k++) push_exp(1'b1, 32'h13572468, 1'b0);
    run_both(3);
    mem_lat = 0;
    d_we = 1'b0; d_addr = 32'h600; d_be = 4'hF;
    i_req = 1'b1; d_req = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock);
      if (mem_req) hit = 1;
    end
    if (!hit) chk("abort_mem_req_wait", 32'h0, 32'h1);
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_acks", {30'h0, i_ack, d_ack}, 32'h0);
    chk("abort_grant_d", {31'h0, grant_d}, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);

    // streak restarts from 0: four data grants before fetch
    mem_lat = 1;
    for (int k = 0; k < 5; k++) push_exp(k != 4, 32'h13572468, 1'b0);
    run_both(5);
    repeat (4) @(negedge clock);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
